btle_hci_cmd_parser: RTL

//  Upstream command stage of btle_ll: consumes bytes from uart_frame_rx, deframes and checks

---
 rtl/btle_hci_cmd_parser.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/btle_hci_cmd_parser.sv
// Host command deframer for btle_ll: checks SYNC/OPC/LEN/PAYLOAD/CHK frames, buffers the
// payload and commits it as config writes, TX PDU writes or a TX start, then returns ACK/NAK.
module btle_hci_cmd_parser #(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_frame,
  input  logic       rx_done,
  input  logic       frame_error,
  output logic       tx_frame_en,
  output logic [7:0] tx_data_frame,
  input  logic       tx_done,
  output logic       cfg_we,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_wdata,
  output logic       pdu_we,
  output logic [5:0] pdu_addr,
  output logic [7:0] pdu_wdata,
  output logic       tx_start_req,
  output logic       busy
);

  // state      | meaning
  // ST_IDLE    | hunting for SYNC (0xA5)
  // ST_OPC     | waiting for opcode byte
  // ST_LEN     | waiting for length byte
  // ST_PAYLOAD | collecting LEN payload bytes
  // ST_CHK     | waiting for checksum byte, decides ACK/NAK
  // ST_COMMIT  | issuing remaining writes, one per clk
  // ST_RESP    | tx_frame_en asserted for this one cycle
  // ST_WAIT_TX | holding the response byte until tx_done

  localparam int CW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] OPC_WRITE_REG = 8'h01;
  localparam logic [7:0] OPC_WRITE_PDU = 8'h02;
  localparam logic [7:0] OPC_START     = 8'h03;
  localparam logic [7:0] RESP_ACK      = 8'h06;
  localparam logic [7:0] RESP_NAK      = 8'h15;
  localparam logic [7:0] MAX_LEN_B     = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_COMMIT,
    ST_RESP,
    ST_WAIT_TX
  } state_t;

  state_t          state;
  logic [7:0]      opc;
  logic [7:0]      len;
  logic [7:0]      rem;
  logic [7:0]      chk;
  logic [CW-1:0]   count;
  logic            err;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      pay_buf [MAX_LEN];

  logic            in_frame;
  logic            is_reg;
  logic            is_pdu;
  logic            is_start;
  logic            len_fits;
  logic            len_ok;
  logic            chk_ok;
  logic            wr_more;
  logic            tmo_hit;
  logic [CW-1:0]   first_idx;
  logic [CW-1:0]   wr_idx;
  logic [7:0]      reg_addr;

  always_comb begin
    in_frame  = (state == ST_OPC) || (state == ST_LEN) ||
                (state == ST_PAYLOAD) || (state == ST_CHK);
    is_reg    = (opc == OPC_WRITE_REG);
    is_pdu    = (opc == OPC_WRITE_PDU);
    is_start  = (opc == OPC_START);
    len_fits  = (len < MAX_LEN_B);
    len_ok    = (is_reg   && (len >= 8'd2) && len_fits) ||
                (is_pdu   && (len >= 8'd1) && len_fits) ||
                (is_start && (len == 8'd0));
    chk_ok    = (rx_frame == chk) && len_ok && !err && !frame_error;
    // WRITE_REG spends P[0] on the base address, so its data starts at index 1
    first_idx = is_reg ? CW'(1) : CW'(0);
    wr_idx    = (state == ST_CHK) ? first_idx : count;
    wr_more   = (8'(count) < len);
    reg_addr  = pay_buf[0] + 8'(wr_idx) - 8'd1;
    tmo_hit   = in_frame && !rx_done && (tmo_cnt == TMO_LAST);
  end

  assign busy = (state != ST_IDLE);

  // Payload storage has no reset; it is only read after being filled by the current frame.
  always_ff @(posedge clk) begin
    if ((state == ST_PAYLOAD) && rx_done && len_fits)
      pay_buf[count] <= rx_frame;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      opc           <= 8'd0;
      len           <= 8'd0;
      rem           <= 8'd0;
      chk           <= 8'd0;
      count         <= '0;
      err           <= 1'b0;
      tmo_cnt       <= '0;
      tx_frame_en   <= 1'b0;
      tx_data_frame <= 8'd0;
      cfg_we        <= 1'b0;
      cfg_addr      <= 8'd0;
      cfg_wdata     <= 8'd0;
      pdu_we        <= 1'b0;
      pdu_addr      <= 6'd0;
      pdu_wdata     <= 8'd0;
      tx_start_req  <= 1'b0;
    end else begin
      cfg_we       <= 1'b0;
      pdu_we       <= 1'b0;
      tx_frame_en  <= 1'b0;
      tx_start_req <= 1'b0;

      if (in_frame && !rx_done)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      case (state)
        ST_IDLE: begin
          if (rx_done && !frame_error && (rx_frame == SYNC_BYTE)) begin
            state <= ST_OPC;
            count <= '0;
            chk   <= 8'd0;
            err   <= 1'b0;
          end
        end
        ST_OPC: begin
          if (rx_done) begin
            opc   <= rx_frame;
            chk   <= rx_frame;
            err   <= err | frame_error;
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_done) begin
            len   <= rx_frame;
            rem   <= rx_frame;
            chk   <= chk ^ rx_frame;
            err   <= err | frame_error;
            state <= (rx_frame == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          // 0xA5 here is ordinary data; only the byte count ends the payload
          if (rx_done) begin
            chk   <= chk ^ rx_frame;
            count <= count + 1'b1;
            rem   <= rem - 8'd1;
            err   <= err | frame_error;
            if (rem == 8'd1)
              state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (rx_done) begin
            if (chk_ok) begin
              state <= ST_COMMIT;
              if (is_start) begin
                tx_start_req <= 1'b1;
              end else begin
                count <= wr_idx + 1'b1;
                if (is_pdu) begin
                  pdu_we    <= 1'b1;
                  pdu_addr  <= 6'(wr_idx);
                  pdu_wdata <= pay_buf[wr_idx];
                end else begin
                  cfg_we    <= 1'b1;
                  cfg_addr  <= reg_addr;
                  cfg_wdata <= pay_buf[wr_idx];
                end
              end
            end else begin
              tx_frame_en   <= 1'b1;
              tx_data_frame <= RESP_NAK;
              state         <= ST_RESP;
            end
          end
        end
        ST_COMMIT: begin
          if (!is_start && wr_more) begin
            count <= count + 1'b1;
            if (is_pdu) begin
              pdu_we    <= 1'b1;
              pdu_addr  <= 6'(wr_idx);
              pdu_wdata <= pay_buf[wr_idx];
            end else begin
              cfg_we    <= 1'b1;
              cfg_addr  <= reg_addr;
              cfg_wdata <= pay_buf[wr_idx];
            end
          end else begin
            tx_frame_en   <= 1'b1;
            tx_data_frame <= RESP_ACK;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // a stalled host abandons the frame without any response
      if (tmo_hit) begin
        state <= ST_IDLE;
        err   <= 1'b0;
      end
    end
  end

endmodule
